// File: rtl/counter_bank_if.sv
// Bus bundle for counter_bank: operation request, read address and read results.
// master drives operations and read address; slave is the counter bank itself.
`timescale 1ns/1ps
interface counter_bank_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2
);
    logic              op_valid;
    logic [ADDR_W-1:0] op_addr;
    logic [1:0]        op_code;
    logic [WIDTH-1:0]  immediate;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_ovf;
    logic              ovf_any;

    modport master (
        output op_valid, op_addr, op_code, immediate, rd_addr,
        input  rd_data, rd_ovf, ovf_any
    );

    modport slave (
        input  op_valid, op_addr, op_code, immediate, rd_addr,
        output rd_data, rd_ovf, ovf_any
    );
endinterface

// File: rtl/counter_bank.sv
// counter_bank: DEPTH = 2**ADDR_W counters of WIDTH bits, each with a sticky overflow flag.
// Operations (inc/dec/load/clear) are applied on the falling clock edge; reads are
// combinational from stored state. Reset is asynchronous, active-high.
// Build option: define COUNTER_BANK_SAT_EN to saturate on overflow instead of wrapping.
`timescale 1ns/1ps
module counter_bank #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    counter_bank_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OpInc   = 2'b00,
        OpDec   = 2'b01,
        OpLoad  = 2'b10,
        OpClear = 2'b11
    } op_e;

    logic [WIDTH-1:0] cnt_q [DEPTH];
    logic [DEPTH-1:0] ovf_q;

    logic [WIDTH-1:0] cur_cnt;
    logic             cur_ovf;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] nxt_cnt;
    logic             nxt_ovf;

    // Next value and flag for the addressed counter only.
    always_comb begin
        cur_cnt = cnt_q[bus.op_addr];
        cur_ovf = ovf_q[bus.op_addr];
        // One extra bit keeps the carry out of the true sum.
        sum     = {1'b0, cur_cnt} + {1'b0, bus.immediate};
        diff    = cur_cnt - bus.immediate;
        nxt_cnt = cur_cnt;
        nxt_ovf = cur_ovf;
        unique case (op_e'(bus.op_code))
            OpInc: begin
                if (sum[WIDTH]) begin
                    nxt_ovf = 1'b1;
`ifdef COUNTER_BANK_SAT_EN
                    nxt_cnt = '1;
`else
                    nxt_cnt = sum[WIDTH-1:0];
`endif
                end else begin
                    nxt_cnt = sum[WIDTH-1:0];
                end
            end
            OpDec: begin
                if (bus.immediate > cur_cnt) begin
                    nxt_ovf = 1'b1;
`ifdef COUNTER_BANK_SAT_EN
                    nxt_cnt = '0;
`else
                    nxt_cnt = diff;
`endif
                end else begin
                    nxt_cnt = diff;
                end
            end
            OpLoad: begin
                nxt_cnt = bus.immediate;
                nxt_ovf = 1'b0;
            end
            OpClear: begin
                nxt_cnt = '0;
                nxt_ovf = 1'b0;
            end
        endcase
    end

    // Counter and flag storage: falling-edge update, async clear holds while rst is high.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (bus.op_valid) begin
            cnt_q[bus.op_addr] <= nxt_cnt;
            ovf_q[bus.op_addr] <= nxt_ovf;
        end
    end

    // Side-effect-free read port and global overflow summary.
    always_comb begin
        bus.rd_data = cnt_q[bus.rd_addr];
        bus.rd_ovf  = ovf_q[bus.rd_addr];
        bus.ovf_any = |ovf_q;
    end
endmodule
